// File: rtl/uart_tx_queue.sv
// Transmit byte queue feeding the UART: buffers CPU writes and hands them to
// the transmitter one at a time. A byte is popped only after busy_flag shows
// the transmitter accepted it.
module uart_tx_queue #(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned PTR_W          = 4,
  parameter int unsigned ACCEPT_TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             flush,
  input  logic             clr_ovf,
  input  logic             tx_en,
  input  logic             busy_flag,
  output logic             begin_flag,
  output logic [7:0]       tx_data,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count,
  output logic             overflow
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMR_W = (ACCEPT_TIMEOUT < 2) ? 1 : $clog2(ACCEPT_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         mem_q [DEPTH];
  logic [7:0]         mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               begin_q, begin_d;
  logic               overflow_q, overflow_d;
  logic               full_w, empty_w;
  logic               push, pop;

  assign full_w     = (count_q == CNT_W'(DEPTH));
  assign empty_w    = (count_q == '0);
  assign full       = full_w;
  assign empty      = empty_w;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign begin_flag = begin_q;
  assign tx_data    = empty_w ? 8'h00 : mem_q[rd_ptr_q];

  // Handshake FSM, FIFO pointer/count bookkeeping and overflow flag.
  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    timer_d    = timer_q;
    begin_d    = 1'b0;
    overflow_d = overflow_q;
    pop        = 1'b0;
    push       = wr_en && !full_w && !flush;

    case (state_q)
      IDLE: begin
        if (!empty_w && tx_en && !busy_flag && !flush) begin
          begin_d = 1'b1;
          timer_d = '0;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (flush) begin
          state_d = IDLE;
        end else if (busy_flag) begin
          pop     = 1'b1;
          state_d = WAIT_DONE;
        end else if (timer_q == TMR_W'(ACCEPT_TIMEOUT - 1)) begin
          // Strobe was missed; fall back so the same head byte is re-issued.
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      WAIT_DONE: begin
        // An in-flight byte is already popped, so flush does not disturb it.
        if (!busy_flag) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    // Dropped write wins over a simultaneous clear.
    if (wr_en && full_w) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      begin_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      begin_q    <= begin_d;
      overflow_q <= overflow_d;
    end
  end

  // Queue storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: behavioural transmitter model plus byte scoreboard.
`timescale 1ns/1ps
module tb_uart_tx_queue;

  localparam int unsigned DEPTH          = 16;
  localparam int unsigned PTR_W          = 4;
  localparam int unsigned ACCEPT_TIMEOUT = 4;
  localparam int unsigned CW             = PTR_W + 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           wr_en;
  logic [7:0]     wr_data;
  logic           flush;
  logic           clr_ovf;
  logic           tx_en;
  logic           busy_flag;
  logic           begin_flag;
  logic [7:0]     tx_data;
  logic           full;
  logic           empty;
  logic [PTR_W:0] count;
  logic           overflow;

  int tests = 0;
  int fails = 0;

  logic [7:0] sb[$];
  int         bcyc_q[$];
  logic [7:0] bdat_q[$];
  int         cseq[$];
  int         last_cnt = 0;

  int         cyc = 0;
  int         ignore_cnt = 0;
  int         busy_len = 20;
  int         m_state = 0;
  int         m_left = 0;
  int         n_acc = 0;
  logic [7:0] acc_data = 8'h00;
  logic       prev_begin = 1'b0;
  int         fall_cyc = 0;
  bit         fall_valid = 1'b0;

  uart_tx_queue #(
    .DEPTH(DEPTH), .PTR_W(PTR_W), .ACCEPT_TIMEOUT(ACCEPT_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .flush(flush), .clr_ovf(clr_ovf), .tx_en(tx_en), .busy_flag(busy_flag),
    .begin_flag(begin_flag), .tx_data(tx_data), .full(full), .empty(empty),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Transmitter model: optionally ignores strobes, otherwise raises busy one
  // cycle after the strobe and holds it for busy_len cycles.
  initial begin
    busy_flag = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        m_state = 0; busy_flag = 1'b0; prev_begin = 1'b0; fall_valid = 1'b0;
        continue;
      end
      if (begin_flag) begin
        tests++;
        if (prev_begin) begin
          fails++;
          $display("FAIL begin_width: begin_flag high on consecutive cycles at cyc %0d, required single cycle", cyc);
        end
        if (fall_valid) begin
          tests++;
          if (cyc - fall_cyc < 2) begin
            fails++;
            $display("FAIL strobe_gap: strobe %0d cycles after busy fell, required >= 2", cyc - fall_cyc);
          end
        end
        bcyc_q.push_back(cyc);
        bdat_q.push_back(tx_data);
      end
      prev_begin = begin_flag;
      case (m_state)
        0: if (begin_flag) begin
          if (ignore_cnt > 0) begin
            ignore_cnt--;
          end else begin
            tests++;
            if (sb.size() == 0) begin
              fails++;
              $display("FAIL sb_extra: got byte %02h, required none", tx_data);
            end else begin
              if (tx_data !== sb[0]) begin
                fails++;
                $display("FAIL sb_order: got %02h, required %02h", tx_data, sb[0]);
              end
              void'(sb.pop_front());
            end
            acc_data = tx_data;
            n_acc++;
            m_state = 1;
          end
        end
        1: begin
          tests++;
          if (tx_data !== acc_data) begin
            fails++;
            $display("FAIL tx_stable: got %02h, required %02h", tx_data, acc_data);
          end
          busy_flag = 1'b1;
          m_left = busy_len;
          m_state = 2;
        end
        default: begin
          m_left--;
          if (m_left <= 0) begin
            busy_flag = 1'b0;
            fall_cyc = cyc;
            fall_valid = 1'b1;
            m_state = 0;
          end
        end
      endcase
    end
  end

  task automatic step();
    @(negedge clk);
    if (int'(count) != last_cnt) begin
      last_cnt = int'(count);
      cseq.push_back(last_cnt);
    end
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n;
    n = 0;
    while (!(empty && !busy_flag && m_state == 0) && n < limit) begin
      step();
      n++;
    end
    tests++;
    if (n >= limit) begin
      fails++;
      $display("FAIL %s_timeout: queue not drained after %0d cycles, count=%0d", name, limit, count);
    end
    step(); step();
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
    clr_ovf = 1'b0; tx_en = 1'b0;
    @(negedge clk);
    tests++; if (begin_flag !== 1'b0) begin fails++; $display("FAIL rst_begin: got %b required 0", begin_flag); end
    tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL rst_tx_data: got %02h required 00", tx_data); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL rst_full: got %b required 0", full); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL rst_empty: got %b required 1", empty); end
    tests++; if (count !== CW'(0)) begin fails++; $display("FAIL rst_count: got %0d required 0", count); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rst_overflow: got %b required 0", overflow); end
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic test_burst();
    int exp_c[6] = '{1, 2, 3, 2, 1, 0};
    busy_len = 20; tx_en = 1'b1;
    cseq.delete(); last_cnt = int'(count);
    wr_en = 1'b1; wr_data = 8'h41; sb.push_back(8'h41);
    step();
    tests++;
    if (count !== CW'(1) || begin_flag !== 1'b0) begin
      fails++; $display("FAIL burst_lat_n: count=%0d begin=%b, required 1 and 0", count, begin_flag);
    end
    wr_data = 8'h42; sb.push_back(8'h42);
    step();
    tests++;
    if (begin_flag !== 1'b1 || tx_data !== 8'h41) begin
      fails++; $display("FAIL burst_lat_begin: begin=%b tx_data=%02h, required 1 and 41", begin_flag, tx_data);
    end
    wr_data = 8'h43; sb.push_back(8'h43);
    step();
    wr_en = 1'b0;
    wait_drain("burst", 300);
    tests++;
    if (cseq.size() != 6) begin
      fails++; $display("FAIL burst_count_len: got %0d count changes, required 6", cseq.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests++;
        if (cseq[i] != exp_c[i]) begin
          fails++; $display("FAIL burst_count_seq[%0d]: got %0d required %0d", i, cseq[i], exp_c[i]);
        end
      end
    end
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL burst_sb_left: got %0d bytes left, required 0", sb.size()); end
  endtask

  task automatic test_overflow();
    tx_en = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'h80 + 8'(i);
      if (i < 16) sb.push_back(8'h80 + 8'(i));
      step();
      if (i == 15) begin
        tests++;
        if (full !== 1'b1 || overflow !== 1'b0 || count !== CW'(16)) begin
          fails++; $display("FAIL ovf_full: full=%b ovf=%b count=%0d, required 1 0 16", full, overflow, count);
        end
      end
    end
    wr_en = 1'b0;
    tests++;
    if (overflow !== 1'b1 || count !== CW'(16)) begin
      fails++; $display("FAIL ovf_drop: ovf=%b count=%0d, required 1 16", overflow, count);
    end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    tests++;
    if (overflow !== 1'b0 || count !== CW'(16)) begin
      fails++; $display("FAIL ovf_clear: ovf=%b count=%0d, required 0 16", overflow, count);
    end
    busy_len = 3; tx_en = 1'b1;
    wait_drain("ovf", 600);
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL ovf_sb_left: got %0d bytes left, required 0", sb.size()); end
  endtask

  task automatic test_timeout();
    bit cnt_bad;
    int n;
    cnt_bad = 1'b0; n = 0;
    busy_len = 3; tx_en = 1'b1; ignore_cnt = 1;
    bcyc_q.delete(); bdat_q.delete();
    wr_en = 1'b1; wr_data = 8'h5A; sb.push_back(8'h5A);
    step();
    wr_en = 1'b0;
    while (bcyc_q.size() < 2 && n < 50) begin
      if (count !== CW'(1)) cnt_bad = 1'b1;
      step();
      n++;
    end
    tests++;
    if (bcyc_q.size() < 2) begin
      fails++; $display("FAIL to_reissue: got %0d strobes, required 2", bcyc_q.size());
    end else begin
      tests++;
      if (bdat_q[0] !== 8'h5A || bdat_q[1] !== 8'h5A) begin
        fails++; $display("FAIL to_data: got %02h/%02h required 5A/5A", bdat_q[0], bdat_q[1]);
      end
      // Four cycles in WAIT_BUSY, then one in IDLE before the re-strobe.
      tests++;
      if (bcyc_q[1] - bcyc_q[0] != int'(ACCEPT_TIMEOUT) + 1) begin
        fails++; $display("FAIL to_gap: got %0d cycles between strobes, required %0d", bcyc_q[1] - bcyc_q[0], int'(ACCEPT_TIMEOUT) + 1);
      end
    end
    tests++;
    if (cnt_bad) begin fails++; $display("FAIL to_count: count changed before acceptance, required 1"); end
    wait_drain("timeout", 100);
  endtask

  task automatic test_wrap();
    int acc0;
    acc0 = n_acc;
    busy_len = 2; tx_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      wr_en = 1'b1; wr_data = b; sb.push_back(b);
      step();
      wr_en = 1'b0;
      step();
    end
    wait_drain("wrap", 400);
    tests++;
    if (empty !== 1'b1 || overflow !== 1'b0) begin
      fails++; $display("FAIL wrap_end: empty=%b ovf=%b, required 1 0", empty, overflow);
    end
    tests++;
    if (n_acc - acc0 != 20 || sb.size() != 0) begin
      fails++; $display("FAIL wrap_cnt: accepted %0d with %0d left, required 20 and 0", n_acc - acc0, sb.size());
    end
  endtask

  task automatic test_flush();
    int nb;
    int n;
    n = 0;
    tx_en = 1'b0; ignore_cnt = 1000;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    tx_en = 1'b1;
    while (begin_flag !== 1'b1 && n < 10) begin step(); n++; end
    tests++;
    if (begin_flag !== 1'b1) begin fails++; $display("FAIL fl_begin: got begin=%b, required 1", begin_flag); end
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    step();
    flush = 1'b0; wr_en = 1'b0;
    tests++;
    if (count !== CW'(0) || empty !== 1'b1 || begin_flag !== 1'b0) begin
      fails++; $display("FAIL fl_clear: count=%0d empty=%b begin=%b, required 0 1 0", count, empty, begin_flag);
    end
    nb = bcyc_q.size();
    repeat (10) step();
    tests++;
    if (bcyc_q.size() != nb || count !== CW'(0)) begin
      fails++; $display("FAIL fl_quiet: %0d new strobes count=%0d, required 0 and 0", bcyc_q.size() - nb, count);
    end
    ignore_cnt = 0;
    wr_en = 1'b1; wr_data = 8'h77; sb.push_back(8'h77);
    step();
    wr_en = 1'b0;
    step();
    tests++;
    if (begin_flag !== 1'b1 || tx_data !== 8'h77) begin
      fails++; $display("FAIL fl_idle: begin=%b tx_data=%02h, required 1 77", begin_flag, tx_data);
    end
    wait_drain("flush", 100);
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL fl_sb_left: got %0d bytes, required 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    busy_len = 20; tx_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'hC0 + 8'(i); sb.push_back(8'hC0 + 8'(i));
      step();
    end
    wr_en = 1'b0;
    while (busy_flag !== 1'b1 && n < 20) begin step(); n++; end
    step();
    tests++;
    if (count !== CW'(3) || busy_flag !== 1'b1) begin
      fails++; $display("FAIL rm_pre: count=%0d busy=%b, required 3 1", count, busy_flag);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (begin_flag !== 1'b0 || tx_data !== 8'h00 || full !== 1'b0 || overflow !== 1'b0) begin
      fails++; $display("FAIL rm_outs: begin=%b tx=%02h full=%b ovf=%b, required 0 00 0 0", begin_flag, tx_data, full, overflow);
    end
    tests++;
    if (count !== CW'(0) || empty !== 1'b1) begin
      fails++; $display("FAIL rm_count: count=%0d empty=%b, required 0 1", count, empty);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_burst();
    test_overflow();
    test_timeout();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Transmit-side byte queue that sits directly upstream of the UART transmitter. The CPU writes bytes into a DEPTH-entry FIFO, and the block drains the FIFO into the transmitter one byte at a time. For each byte it issues a one-cycle `begin_flag` with `tx_data` stable, then tracks the transmitter's `busy_flag` until the frame completes. This lets software queue a burst of bytes without polling `busy_flag` between them.

## Interface
- `DEPTH`, 16, FIFO entries; must be a power of two, ≥ 2.
- `PTR_W`, 4, log2(DEPTH).
- `ACCEPT_TIMEOUT`, 4, cycles to wait for `busy_flag` after `begin_flag` before re-issuing the byte.

- `clk` in 1: system clock; all state changes on posedge.
- `reset` in 1: reset, asynchronous, active-high.
- `wr_en` in 1: push `wr_data` this cycle.
- `wr_data` in 8: byte to queue.
- `flush` in 1: synchronous queue clear.
- `clr_ovf` in 1: clears `overflow`.
- `tx_en` in 1: drain enable; when low, no new `begin_flag` is issued.
- `busy_flag` in 1: transmitter busy, from the UART.
- `begin_flag` out 1: one-cycle start strobe to the UART.
- `tx_data` out 8: byte to the UART.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `count` out PTR_W+1: queued bytes, including the head, until it is popped.
- `overflow` out 1: sticky; set when a write is dropped.

## Operation
- FIFO: `mem[DEPTH]`, `wr_ptr` and `rd_ptr` are PTR_W bits and wrap modulo DEPTH. `count` is a separate PTR_W+1 counter.
- Push: on `wr_en && !full && !flush`, store at `wr_ptr`, then `wr_ptr+1`.
- Dropped write: `wr_en && full` drops the byte and sets `overflow`. This applies even if a pop occurs in the same cycle, because `full` is evaluated before the edge.
- Push and pop in the same cycle: `count` is unchanged and both pointers advance.
- `tx_data` = `mem[rd_ptr]` when `!empty`, else 8'h00. Combinational from registered state.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
  - IDLE: when `!empty && tx_en && !busy_flag`, set `begin_flag`←1, `timer`←0, go to WAIT_BUSY.
  - WAIT_BUSY: `begin_flag`←0.
    - If `busy_flag`: pop the head (`rd_ptr+1`, `count−1`), go to WAIT_DONE.
    - Else `timer+1`. When `timer == ACCEPT_TIMEOUT−1`, go to IDLE without popping; the same byte is re-issued.
  - WAIT_DONE: when `!busy_flag`, go to IDLE.
- A byte is popped only once the transmitter has accepted it (`busy_flag` seen high), so a missed strobe never loses data.
- `flush` (priority over `wr_en`):
  - Clears pointers and `count`.
  - From WAIT_BUSY, goes to IDLE with `begin_flag`←0.
  - From WAIT_DONE, stays in WAIT_DONE; the in-flight byte was already popped and finishes normally.
- `overflow`: `clr_ovf` clears it. Setting has priority if both occur in the same cycle.
- `tx_en` falling mid-frame does not abort; it only blocks the next IDLE→WAIT_BUSY transition.

## Timing
- Reset (async) forces:
  - `begin_flag`=0, `tx_data`=8'h00
  - `full`=0, `empty`=1, `count`=0, `overflow`=0
  - pointers=0, `timer`=0, state=IDLE
- Reset asserted mid-frame discards the queue; the UART is reset by the same signal.
- Write-to-begin latency, empty queue, `busy_flag` low: `wr_en` at edge N updates `count` at N; `begin_flag` is high during cycle N+1→N+2 (registered at edge N+1).
- `begin_flag` width is exactly 1 cycle. `tx_data` is stable from `begin_flag` assertion until the pop edge.
- Pop occurs at the first edge in WAIT_BUSY that samples `busy_flag`=1.
- Minimum gap between strobes: the frame time plus 2 cycles (WAIT_DONE→IDLE→`begin_flag`).
- `full`, `empty`, `count` are registered and update on the edge of the push or pop.

## Test plan
- Reset mid-WAIT_DONE with 3 bytes queued → all outputs take their reset values immediately; `count`=0, `empty`=1.
- Write 0x41, 0x42, 0x43 with a transmitter model that raises `busy` 1 cycle after begin and holds it 20 cycles → three 1-cycle `begin_flag` pulses with `tx_data` 0x41, 0x42, 0x43 in order; `count` goes 3→2→1→0; every strobe is ≥2 cycles after `busy` falls.
- Write 17 bytes with `tx_en`=0 and DEPTH=16 → `full`=1 after the 16th; the 17th is dropped with `overflow`=1; raise `clr_ovf` → `overflow`=0 and `count` stays 16.
- Transmitter model ignores the first begin (`busy` stays low) → `begin_flag` is re-issued after 4 cycles with the same `tx_data`; `count` is unchanged until `busy` is seen.
- Fill with 20 writes to wrap the pointers (DEPTH=16, draining concurrently) → output order equals input order across the wrap; `empty`=1 at the end.
- `flush` while in WAIT_BUSY with 5 bytes queued → `count`=0, state returns to IDLE, no further `begin_flag`. `flush` in the same cycle as `wr_en` → the byte is not stored.
